// File: rtl/run_controller_pkg.sv
//==============================================================================
// run_ctrl_pkg : shared state/stop-cause encodings for run_controller   rev 1.0
//==============================================================================
`default_nettype none

package run_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_HALTED = 2'd2
   } run_state_t;

   typedef enum logic [2:0] {
      SC_NONE  = 3'd0,
      SC_STOP  = 3'd1,
      SC_HALT  = 3'd2,
      SC_BP    = 3'd3,
      SC_COUNT = 3'd4
   } stop_cause_t;

   localparam int RETIRED_W = 16;

endpackage

`default_nettype wire

// File: rtl/run_controller_if.sv
//==============================================================================
// run_controller_if : request/status bundle between board logic and sequencer
//==============================================================================
`default_nettype none

interface run_controller_if #(
   parameter int ADDR_W = 5,
   parameter int CNT_W  = 8,
   parameter int DIV_W  = 24
) ();

   logic                                step_req;
   logic                                run_req;
   logic                                stop_req;
   logic [CNT_W-1:0]                    run_count;
   logic [DIV_W-1:0]                    rate_div;
   logic                                bp_en;
   logic [ADDR_W-1:0]                   bp_addr;
   logic [ADDR_W-1:0]                   curr_inst_addr;
   logic                                halt;
   logic                                exec_en;
   logic [1:0]                          state;
   logic [2:0]                          stop_cause;
   logic [run_ctrl_pkg::RETIRED_W-1:0]  retired;

   modport master (
      output step_req, run_req, stop_req, run_count, rate_div,
             bp_en, bp_addr, curr_inst_addr, halt,
      input  exec_en, state, stop_cause, retired
   );

   modport slave (
      input  step_req, run_req, stop_req, run_count, rate_div,
             bp_en, bp_addr, curr_inst_addr, halt,
      output exec_en, state, stop_cause, retired
   );

endinterface

`default_nettype wire

// File: rtl/run_controller_rate_divider.sv
//==============================================================================
// rate_divider : loadable auto-reload down-counter, tick while count is 0
//==============================================================================
`default_nettype none

module rate_divider #(
   parameter int DIV_W = 24
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             advance,
   input  logic [DIV_W-1:0] period,
   output logic             tick
);

   logic [DIV_W-1:0] count;
   logic [DIV_W-1:0] reload;
   logic [DIV_W-1:0] start;

   // A period of 0 behaves like 1: issue every cycle.
   assign start = (period == '0) ? '0 : period - DIV_W'(1);
   assign tick  = (count == '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         count  <= '0;
         reload <= '0;
      end else if (load) begin
         count  <= start;
         reload <= start;
      end else if (advance) begin
         count  <= tick ? reload : count - DIV_W'(1);
      end
   end

endmodule

`default_nettype wire

// File: rtl/run_controller.sv
//==============================================================================
// run_controller : exec_en sequencer (single-step, rate run, bounded run) rev 1.0
//==============================================================================
`default_nettype none

module run_controller
   import run_ctrl_pkg::*;
#(
   parameter int ADDR_W = 5,
   parameter int CNT_W  = 8,
   parameter int DIV_W  = 24
) (
   input  logic             clk,
   input  logic             reset,
   run_controller_if.slave  bus
);

   run_state_t             state_q;
   stop_cause_t            cause_q;
   logic [CNT_W-1:0]       remaining;
   logic                   first;
   logic                   bounded;
   logic [RETIRED_W-1:0]   retired_q;

   logic [ADDR_W-1:0]      pc;
   logic [ADDR_W-1:0]      bp;
   logic                   in_idle;
   logic                   in_run;
   logic                   bp_hit;
   logic                   div_tick;
   logic                   div_load;
   logic                   div_adv;
   logic                   issue;
   logic                   step_issue;
   logic                   exec_en;

   assign pc         = bus.curr_inst_addr;
   assign bp         = bus.bp_addr;
   assign in_idle    = (state_q == ST_IDLE);
   assign in_run     = (state_q == ST_RUN);
   // first masks the breakpoint so a run can resume from the breakpointed PC.
   assign bp_hit     = bus.bp_en && (pc == bp) && !first;
   assign div_load   = in_idle && !bus.halt && bus.run_req;
   assign div_adv    = in_run && !bus.halt && !bus.stop_req && !bp_hit;
   assign issue      = div_adv && div_tick;
   assign step_issue = in_idle && bus.step_req && !bus.run_req;
   assign exec_en    = !reset && !bus.halt && (step_issue || issue);

   rate_divider #(
      .DIV_W (DIV_W)
   ) u_div (
      .clk     (clk),
      .reset   (reset),
      .load    (div_load),
      .advance (div_adv),
      .period  (bus.rate_div),
      .tick    (div_tick)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         cause_q   <= SC_NONE;
         remaining <= '0;
         first     <= 1'b0;
         bounded   <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (bus.halt) begin
                  state_q <= ST_HALTED;
                  cause_q <= SC_HALT;
               end else if (bus.run_req) begin
                  state_q   <= ST_RUN;
                  cause_q   <= SC_NONE;
                  remaining <= bus.run_count;
                  bounded   <= (bus.run_count != '0);
                  first     <= 1'b1;
               end
            end
            ST_RUN: begin
               if (bus.halt) begin
                  state_q <= ST_HALTED;
                  cause_q <= SC_HALT;
               end else if (bus.stop_req) begin
                  state_q <= ST_IDLE;
                  cause_q <= SC_STOP;
               end else if (bp_hit) begin
                  state_q <= ST_IDLE;
                  cause_q <= SC_BP;
               end else if (div_tick) begin
                  first <= 1'b0;
                  if (bounded) begin
                     remaining <= remaining - CNT_W'(1);
                     if (remaining == CNT_W'(1)) begin
                        state_q <= ST_IDLE;
                        cause_q <= SC_COUNT;
                     end
                  end
               end
            end
            ST_HALTED: begin
               state_q <= ST_HALTED;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         retired_q <= '0;
      end else if (exec_en && (retired_q != '1)) begin
         retired_q <= retired_q + RETIRED_W'(1);
      end
   end

   assign bus.exec_en    = exec_en;
   assign bus.state      = state_q;
   assign bus.stop_cause = cause_q;
   assign bus.retired    = retired_q;

endmodule

`default_nettype wire

// File: tb/tb_run_controller.sv
//==============================================================================
// tb_run_controller : scoreboard bench for run_controller
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_run_controller;

   logic       clk = 1'b0;
   logic       reset;
   int         cyc = 0;
   logic [4:0] pc;
   logic       halt_force;
   logic       halt_at7;
   int         exp_q[$];
   int         n_tests = 0;
   int         n_fail  = 0;

   run_controller_if #(.ADDR_W(5), .CNT_W(8), .DIV_W(24)) bus ();

   run_controller #(.ADDR_W(5), .CNT_W(8), .DIV_W(24)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // PC model: advances on every exec_en
   always @(posedge clk) begin
      if (reset) pc <= 5'd0;
      else if (bus.exec_en === 1'b1) pc <= pc + 5'd1;
   end

   assign bus.curr_inst_addr = pc;
   assign bus.halt = halt_force | (halt_at7 & (pc == 5'd7));

   // Scoreboard: every exec_en pulse must match the next expected issue cycle
   always @(negedge clk) begin
      if (bus.exec_en !== 1'b0) begin
         n_tests++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL exec_en_unexpected: pulse at cycle %0d, none expected", cyc);
         end else begin
            int e;
            e = exp_q.pop_front();
            if (e !== cyc) begin
               n_fail++;
               $display("FAIL exec_en_cycle: got pulse at cycle %0d expected cycle %0d", cyc, e);
            end
         end
      end
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      next_cycle();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) next_cycle();
      reset = 1'b0;
      n_tests++;
      if (bus.state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", bus.state); end
      n_tests++;
      if (bus.stop_cause !== 3'd0) begin n_fail++; $display("FAIL reset_cause: got %0d expected 0", bus.stop_cause); end
      n_tests++;
      if (bus.retired !== 16'd0) begin n_fail++; $display("FAIL reset_retired: got %0d expected 0", bus.retired); end
      n_tests++;
      if (bus.exec_en !== 1'b0) begin n_fail++; $display("FAIL reset_exec_en: got %0b expected 0", bus.exec_en); end
   endtask

   task automatic test_step();
      for (int k = 0; k < 3; k++) begin
         next_cycle();
         bus.step_req = 1'b1;
         exp_q.push_back(cyc);
         next_cycle();
         bus.step_req = 1'b0;
      end
      next_cycle();
      n_tests++;
      if (exp_q.size() != 0) begin n_fail++; $display("FAIL step_missing: got %0d pending expected 0", exp_q.size()); end
      n_tests++;
      if (bus.retired !== 16'd3) begin n_fail++; $display("FAIL step_retired: got %0d expected 3", bus.retired); end
      n_tests++;
      if (bus.state !== 2'd0) begin n_fail++; $display("FAIL step_state: got %0d expected 0", bus.state); end
   endtask

   task automatic test_bounded_run();
      int t;
      next_cycle();
      bus.run_count = 8'd5;
      bus.rate_div  = 24'd4;
      bus.run_req   = 1'b1;
      t = cyc;
      for (int k = 1; k <= 5; k++) exp_q.push_back(t + 4 * k);
      for (int i = 1; i <= 21; i++) begin
         next_cycle();
         if (i == 1) begin
            bus.run_req   = 1'b0;
            bus.run_count = 8'd0;
            bus.rate_div  = 24'd1;
         end
         if (i == 20) begin
            n_tests++;
            if (bus.state !== 2'd1) begin n_fail++; $display("FAIL count_state_run: got %0d expected 1", bus.state); end
         end
      end
      n_tests++;
      if (bus.state !== 2'd0) begin n_fail++; $display("FAIL count_state_idle: got %0d expected 0", bus.state); end
      n_tests++;
      if (bus.stop_cause !== 3'd4) begin n_fail++; $display("FAIL count_cause: got %0d expected 4", bus.stop_cause); end
      n_tests++;
      if (bus.retired !== 16'd8) begin n_fail++; $display("FAIL count_retired: got %0d expected 8", bus.retired); end
      repeat (3) next_cycle();
      n_tests++;
      if (exp_q.size() != 0) begin n_fail++; $display("FAIL count_missing: got %0d pending expected 0", exp_q.size()); end
   endtask

   task automatic test_breakpoint_and_stop();
      int t;
      int u;
      do_reset();
      bus.bp_en     = 1'b1;
      bus.bp_addr   = 5'd3;
      bus.run_count = 8'd0;
      bus.rate_div  = 24'd1;
      bus.run_req   = 1'b1;
      t = cyc;
      exp_q.push_back(t + 1);
      exp_q.push_back(t + 2);
      exp_q.push_back(t + 3);
      next_cycle();
      bus.run_req = 1'b0;
      repeat (3) next_cycle();
      n_tests++;
      if (pc !== 5'd3) begin n_fail++; $display("FAIL bp_pc_at_hit: got %0d expected 3", pc); end
      next_cycle();
      n_tests++;
      if (bus.state !== 2'd0) begin n_fail++; $display("FAIL bp_state: got %0d expected 0", bus.state); end
      n_tests++;
      if (bus.stop_cause !== 3'd3) begin n_fail++; $display("FAIL bp_cause: got %0d expected 3", bus.stop_cause); end
      // resume from the breakpointed PC with rate_div=0 (every cycle)
      bus.rate_div = 24'd0;
      bus.run_req  = 1'b1;
      u = cyc;
      exp_q.push_back(u + 1);
      exp_q.push_back(u + 2);
      next_cycle();
      bus.run_req = 1'b0;
      n_tests++;
      if (bus.state !== 2'd1) begin n_fail++; $display("FAIL bp_resume_state: got %0d expected 1", bus.state); end
      next_cycle();
      n_tests++;
      if (pc !== 5'd4) begin n_fail++; $display("FAIL bp_resume_pc: got %0d expected 4", pc); end
      next_cycle();
      bus.stop_req = 1'b1;
      next_cycle();
      bus.stop_req = 1'b0;
      n_tests++;
      if (bus.state !== 2'd0) begin n_fail++; $display("FAIL stop_state: got %0d expected 0", bus.state); end
      n_tests++;
      if (bus.stop_cause !== 3'd1) begin n_fail++; $display("FAIL stop_cause: got %0d expected 1", bus.stop_cause); end
      n_tests++;
      if (pc !== 5'd5) begin n_fail++; $display("FAIL stop_pc: got %0d expected 5", pc); end
      bus.bp_en = 1'b0;
   endtask

   task automatic test_collision();
      int v;
      next_cycle();
      bus.stop_req = 1'b1;
      next_cycle();
      bus.stop_req = 1'b0;
      n_tests++;
      if (bus.state !== 2'd0) begin n_fail++; $display("FAIL idle_stop_state: got %0d expected 0", bus.state); end
      bus.run_count = 8'd2;
      bus.rate_div  = 24'd2;
      bus.run_req   = 1'b1;
      bus.step_req  = 1'b1;
      v = cyc;
      exp_q.push_back(v + 2);
      exp_q.push_back(v + 4);
      next_cycle();
      bus.run_req  = 1'b0;
      bus.step_req = 1'b0;
      n_tests++;
      if (bus.state !== 2'd1) begin n_fail++; $display("FAIL collide_state: got %0d expected 1", bus.state); end
      n_tests++;
      if (bus.stop_cause !== 3'd0) begin n_fail++; $display("FAIL collide_cause_clear: got %0d expected 0", bus.stop_cause); end
      repeat (4) next_cycle();
      n_tests++;
      if (bus.state !== 2'd0 || bus.stop_cause !== 3'd4) begin
         n_fail++;
         $display("FAIL collide_end: got state %0d cause %0d expected state 0 cause 4", bus.state, bus.stop_cause);
      end
      n_tests++;
      if (exp_q.size() != 0) begin n_fail++; $display("FAIL collide_missing: got %0d pending expected 0", exp_q.size()); end
   endtask

   task automatic test_halt();
      int t;
      do_reset();
      halt_at7      = 1'b1;
      bus.run_count = 8'd0;
      bus.rate_div  = 24'd1;
      bus.run_req   = 1'b1;
      t = cyc;
      for (int k = 1; k <= 7; k++) exp_q.push_back(t + k);
      for (int i = 1; i <= 8; i++) begin
         next_cycle();
         if (i == 1) bus.run_req = 1'b0;
      end
      n_tests++;
      if (bus.exec_en !== 1'b0) begin n_fail++; $display("FAIL halt_gate: got %0b expected 0", bus.exec_en); end
      next_cycle();
      n_tests++;
      if (bus.state !== 2'd2 || bus.stop_cause !== 3'd2) begin
         n_fail++;
         $display("FAIL halt_state: got state %0d cause %0d expected state 2 cause 2", bus.state, bus.stop_cause);
      end
      halt_at7     = 1'b0;
      bus.step_req = 1'b1;
      next_cycle();
      bus.step_req = 1'b0;
      bus.run_req  = 1'b1;
      next_cycle();
      bus.run_req  = 1'b0;
      next_cycle();
      n_tests++;
      if (bus.state !== 2'd2 || bus.retired !== 16'd7 || pc !== 5'd7) begin
         n_fail++;
         $display("FAIL halted_ignore: got state %0d retired %0d pc %0d expected 2 7 7", bus.state, bus.retired, pc);
      end
      do_reset();
      n_tests++;
      if (bus.state !== 2'd0 || bus.retired !== 16'd0 || bus.stop_cause !== 3'd0) begin
         n_fail++;
         $display("FAIL halt_reset: got state %0d retired %0d cause %0d expected 0 0 0", bus.state, bus.retired, bus.stop_cause);
      end
   endtask

   task automatic test_reset_mid_run();
      int t;
      bus.run_count = 8'd0;
      bus.rate_div  = 24'd1;
      bus.run_req   = 1'b1;
      t = cyc;
      exp_q.push_back(t + 1);
      exp_q.push_back(t + 2);
      exp_q.push_back(t + 3);
      next_cycle();
      bus.run_req = 1'b0;
      repeat (3) next_cycle();
      reset = 1'b1;
      #1;
      n_tests++;
      if (bus.exec_en !== 1'b0) begin n_fail++; $display("FAIL midrun_reset_exec: got %0b expected 0", bus.exec_en); end
      next_cycle();
      reset = 1'b0;
      #1;
      n_tests++;
      if (bus.state !== 2'd0 || bus.stop_cause !== 3'd0 || bus.retired !== 16'd0 || bus.exec_en !== 1'b0) begin
         n_fail++;
         $display("FAIL midrun_reset_outputs: got state %0d cause %0d retired %0d exec %0b expected all 0",
                  bus.state, bus.stop_cause, bus.retired, bus.exec_en);
      end
      repeat (3) next_cycle();
      n_tests++;
      if (exp_q.size() != 0) begin n_fail++; $display("FAIL midrun_missing: got %0d pending expected 0", exp_q.size()); end
   endtask

   initial begin
      reset          = 1'b1;
      halt_force     = 1'b0;
      halt_at7       = 1'b0;
      bus.step_req   = 1'b0;
      bus.run_req    = 1'b0;
      bus.stop_req   = 1'b0;
      bus.run_count  = 8'd0;
      bus.rate_div   = 24'd0;
      bus.bp_en      = 1'b0;
      bus.bp_addr    = 5'd0;
      test_reset();
      test_step();
      test_bounded_run();
      test_breakpoint_and_stop();
      test_collision();
      test_halt();
      test_reset_mid_run();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

endmodule

`default_nettype wire

// File: doc/run_controller.md
# run_controller

Execution sequencer for the single-cycle MIPS board top. It replaces direct wiring of the debounced step button to the PC and selector enables. It generates the per-instruction advance enable `exec_en` in three ways: single-step, free-running at a programmable rate, or a bounded run of N instructions. A run stops on core halt, user stop, an instruction-address breakpoint, or count exhaustion.

## Interface
Parameters:
- ADDR_W, 5, instruction address width (matches PC)
- CNT_W, 8, width of run_count
- DIV_W, 24, width of rate_div

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- step_req  in  1  one-cycle pulse, execute one instruction
- run_req  in  1  one-cycle pulse, start run
- stop_req  in  1  one-cycle pulse, abort run
- run_count  in  CNT_W  instructions per run; 0 = unlimited; sampled on run accept
- rate_div  in  DIV_W  clk cycles per issued instruction in RUN; 0 treated as 1; sampled on run accept
- bp_en  in  1  breakpoint enable (level)
- bp_addr  in  ADDR_W  breakpoint instruction address
- curr_inst_addr  in  ADDR_W  current PC value
- halt  in  1  core halt decode of current instruction (combinational, level)
- exec_en  out  1  advance enable to PC and selector; combinational
- state  out  2  IDLE=0, RUN=1, HALTED=2
- stop_cause  out  3  NONE=0, STOP=1, HALT=2, BP=3, COUNT=4
- retired  out  16  saturating count of exec_en cycles

## Operation
- **Registers:** state, div (DIV_W), remaining (CNT_W), first (1), stop_cause, retired.
- **IDLE:**
  - halt=1 → HALTED next cycle, cause HALT; any request in that cycle is ignored.
  - Else run_req → RUN. Load div=max(rate_div,1)-1, remaining=run_count, first=1, cause NONE.
  - Else step_req → exec_en=1 this cycle; stay IDLE.
  - run_req and step_req together: run wins, step is dropped.
  - stop_req has no effect.
- **RUN:** conditions are evaluated each cycle in this priority order.
  - halt=1 → HALTED, cause HALT.
  - stop_req → IDLE, cause STOP.
  - bp_hit = bp_en & curr_inst_addr==bp_addr & !first; if bp_hit → IDLE, cause BP.
  - div==0 → exec_en=1. Then:
    - reload div=max(rate_div_latched,1)-1;
    - clear first;
    - if run_count_latched≠0, decrement remaining; if remaining was 1 → IDLE, cause COUNT.
  - Otherwise div decrements.
  - step_req and run_req are ignored in RUN.
- **HALTED:** exec_en=0, all requests are ignored, exit only by reset.
- **Breakpoint skip:** `first` suppresses the breakpoint for the first issue after each run accept, so a run can resume from a breakpointed address.
- **exec_en:** exec_en = !reset & !halt & ((IDLE & step_req & !run_req) | (RUN & div==0 & !stop_req & !bp_hit)).
- **retired:** increments on every exec_en cycle and saturates at 16'hFFFF. Only reset clears it.

## Timing
- **Reset values:** state=IDLE, div=0, remaining=0, first=0, stop_cause=NONE, retired=0. exec_en=0 during any reset cycle, including reset mid-RUN.
- **Step latency:** step_req at cycle t → exec_en at t (zero latency). The PC updates at the t→t+1 edge.
- **Run start:** run_req accepted at t → state=RUN at t+1.
  - First exec_en at t+rate_div (rate_div≥1).
  - Subsequent exec_en every rate_div cycles; rate_div 0 or 1 gives an issue every cycle.
- **Count stop:** state becomes IDLE in the cycle after the final issue; exactly run_count exec_en pulses per bounded run.
- **Halt gating:** halt blocks exec_en in the same cycle. The halt instruction never advances the PC.
- **Other stops:** stop and breakpoint transitions take effect at the next edge. No exec_en is issued in the detecting cycle.
- **stop_cause:** holds its value until the next run accept or reset.

## Structure
- Shared package `run_ctrl_pkg` holds:
  - `run_state_t` enum (IDLE, RUN, HALTED);
  - `stop_cause_t` enum (NONE, STOP, HALT, BP, COUNT);
  - the 16-bit retired width constant.
- Sub-module `rate_divider`: loadable down-counter with a `load` input, a `tick` output when the count is 0, and auto-reload. It is instantiated once for div.
- At top level, pulse5 drives step_req, pulse4 selects the FPGA source as before, and exec_en replaces pulse5 on the PC and selector enable inputs.

## Test plan
- **Step:** reset, step_req ×3 with halt=0 → exactly 3 single-cycle exec_en pulses, retired=3, state stays 0.
- **Bounded run:** run_count=5, rate_div=4, run_req at t → exec_en at t+4, t+8, t+12, t+16, t+20; state=IDLE at t+21, stop_cause=4, retired=5.
- **Breakpoint:** bp_en=1, bp_addr=3, PC advancing 0,1,2…, rate_div=1, unlimited run → issues at PC 0,1,2; IDLE with cause 3 while PC=3. A second run_req → PC moves 3→4 with no re-trigger.
- **Halt:** halt asserted while PC=7 during RUN → no exec_en in that cycle, state=2, cause 2. Later step_req and run_req are ignored; reset → state 0, retired 0.
- **Stop and collisions:**
  - stop_req in the same cycle as div==0 → no exec_en, cause 1.
  - run_req and step_req in the same IDLE cycle → no exec_en that cycle, state=RUN next cycle.
- **Reset mid-run:** reset during RUN (rate_div=1) → exec_en=0 in the reset cycle, all outputs at reset values next cycle.
